// File: rtl/imem_boot_loader.sv
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Framed byte-stream loader for IMEM port A; holds the CPU in
//             reset until the image is written. LOADER_CHECKSUM_EN adds a
//             trailing XOR checksum byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
   parameter int         ADDR_W    = 12,
   parameter int         MAX_WORDS = 4096,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [3:0]        imem_wea,
   output logic [ADDR_W-1:0] imem_addra,
   output logic [31:0]       imem_dina,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM  = 3'd5,
`endif
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   state_t          r_state;
   logic [1:0]      r_byteIdx;
   logic [23:0]     r_word;
   logic [7:0]      r_lenLo;
   logic [ADDR_W:0] r_wordCount;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      r_csum;
`endif

   logic            w_take;
   logic [15:0]     w_lenN;
   logic [ADDR_W:0] w_nextCount;

   assign w_take      = rx_valid && rx_ready;
   assign w_lenN      = {rx_data, r_lenLo};
   assign w_nextCount = words_loaded + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_byteIdx    <= 2'd0;
         r_word       <= 24'd0;
         r_lenLo      <= 8'd0;
         r_wordCount  <= '0;
         rx_ready     <= 1'b1;
         imem_wea     <= 4'h0;
         imem_addra   <= '0;
         imem_dina    <= 32'd0;
         cpu_rst      <= 1'b1;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum       <= 8'd0;
`endif
      end else begin
         imem_wea <= 4'h0;
         case (r_state)
            S_IDLE: begin
`ifdef LOADER_CHECKSUM_EN
               r_csum <= 8'd0;
`endif
               if (w_take && rx_data == SYNC_BYTE)
                  r_state <= S_LEN0;
            end

            S_LEN0: begin
               if (w_take) begin
                  r_lenLo <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                  r_csum  <= r_csum ^ rx_data;
`endif
                  r_state <= S_LEN1;
               end
            end

            S_LEN1: begin
               if (w_take) begin
`ifdef LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ rx_data;
`endif
                  if (32'(w_lenN) > MAX_WORDS) begin
                     r_state  <= S_ERR;
                     rx_ready <= 1'b0;
                     load_err <= 1'b1;
                  end else if (w_lenN == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state   <= S_CSUM;
`else
                     r_state   <= S_DONE;
                     rx_ready  <= 1'b0;
                     cpu_rst   <= 1'b0;
                     load_done <= 1'b1;
`endif
                  end else begin
                     r_wordCount <= w_lenN[ADDR_W:0];
                     r_byteIdx   <= 2'd0;
                     r_state     <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (w_take) begin
`ifdef LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ rx_data;
`endif
                  r_byteIdx <= r_byteIdx + 2'd1;
                  case (r_byteIdx)
                     2'd0: r_word[7:0]   <= rx_data;
                     2'd1: r_word[15:8]  <= rx_data;
                     2'd2: r_word[23:16] <= rx_data;
                     default: begin
                        // Registered write strobe: lands in the cycle after the 4th byte.
                        imem_wea   <= 4'hF;
                        imem_addra <= words_loaded[ADDR_W-1:0];
                        imem_dina  <= {rx_data, r_word};
                        rx_ready   <= 1'b0;
                        r_state    <= S_WRITE;
                     end
                  endcase
               end
            end

            S_WRITE: begin
               words_loaded <= w_nextCount;
               if (w_nextCount == r_wordCount) begin
`ifdef LOADER_CHECKSUM_EN
                  rx_ready  <= 1'b1;
                  r_state   <= S_CSUM;
`else
                  r_state   <= S_DONE;
                  cpu_rst   <= 1'b0;
                  load_done <= 1'b1;
`endif
               end else begin
                  rx_ready <= 1'b1;
                  r_state  <= S_DATA;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_take) begin
                  rx_ready <= 1'b0;
                  if (rx_data == r_csum) begin
                     r_state   <= S_DONE;
                     cpu_rst   <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     r_state  <= S_ERR;
                     load_err <= 1'b1;
                  end
               end
            end
`endif

            S_DONE: begin
               rx_ready <= 1'b0;
            end

            S_ERR: begin
               rx_ready <= 1'b0;
            end

            default: begin
               r_state  <= S_ERR;
               rx_ready <= 1'b0;
               load_err <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
